// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared divider width and FSM state encodings
package div_unit_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: divider request/result bundle; div_zero_o exists only with DIV_ZERO_DETECT_EN
interface div_unit_if import div_unit_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
  logic start_i;
  logic signed_i;
  logic annul_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic busy_o;
  logic ready_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
`ifdef DIV_ZERO_DETECT_EN
  logic div_zero_o;
`endif
  modport slave (
    input start_i, signed_i, annul_i, dividend_i, divisor_i,
    output busy_o, ready_o, hi_o, lo_o
`ifdef DIV_ZERO_DETECT_EN
    , div_zero_o
`endif
  );
  modport master (
    output start_i, signed_i, annul_i, dividend_i, divisor_i,
    input busy_o, ready_o, hi_o, lo_o
`ifdef DIV_ZERO_DETECT_EN
    , div_zero_o
`endif
  );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring iteration with a WIDTH+1 bit compare/subtract
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] sh;
  logic ge;
  assign sh = {rem_in, quo_in[WIDTH-1]};
  assign ge = sh >= {1'b0, divisor};
  assign rem_out = ge ? WIDTH'(sh - {1'b0, divisor}) : sh[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ge};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring DIV/DIVU producing HI/LO write data; DIV_ZERO_DETECT_EN enables the divide-by-zero shortcut
module div_unit import div_unit_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input logic clk,
  input logic rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  div_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, rem_nx, quo_nx, hi, lo;
  logic qneg, rneg, ready, zero_go, accept, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign accept = state == DIV_IDLE && bus.start_i && !bus.annul_i;
  assign a_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
  assign b_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
  assign a_abs = a_neg ? -bus.dividend_i : bus.dividend_i;
  assign b_abs = b_neg ? -bus.divisor_i : bus.divisor_i;
`ifdef DIV_ZERO_DETECT_EN
  assign zero_go = bus.divisor_i == '0;
`else
  assign zero_go = 1'b0;
`endif
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in(rem), .quo_in(quo), .divisor(dvs), .rem_out(rem_nx), .quo_out(quo_nx)
  );
  // next state: annul wins, a zero divisor may skip straight to DONE, DONE always returns to IDLE
  always_comb begin
    state_nx = bus.annul_i ? DIV_IDLE :
               state == DIV_IDLE ? (bus.start_i ? (zero_go ? DIV_DONE : DIV_BUSY) : DIV_IDLE) :
               state == DIV_BUSY ? (cnt == CW'(WIDTH - 1) ? DIV_DONE : DIV_BUSY) : DIV_IDLE;
  end
  // operand capture, iteration and sign-corrected result write on leaving DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      hi <= '0;
      lo <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= 1'b0;
      if (accept) begin
        cnt <= '0;
        dvs <= b_abs;
        rem <= zero_go ? bus.dividend_i : '0;
        quo <= zero_go ? '1 : a_abs;
        qneg <= !zero_go && (a_neg ^ b_neg);
        rneg <= !zero_go && a_neg;
      end else if (state == DIV_BUSY) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
      end else if (state == DIV_DONE && !bus.annul_i) begin
        hi <= rneg ? -rem : rem;
        lo <= qneg ? -quo : quo;
        ready <= 1'b1;
      end
    end
  end
`ifdef DIV_ZERO_DETECT_EN
  logic zl, dz;
  // remember a zero-divisor request and flag it alongside its ready pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zl <= 1'b0;
      dz <= 1'b0;
    end else begin
      zl <= accept ? zero_go : zl;
      dz <= state == DIV_DONE && !bus.annul_i && zl;
    end
  end
  assign bus.div_zero_o = dz;
`endif
  assign bus.busy_o = state == DIV_BUSY;
  assign bus.ready_o = ready;
  assign bus.hi_o = hi;
  assign bus.lo_o = lo;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed self-checking bench for div_unit
module tb_div_unit;
  import div_unit_pkg::*;
  localparam int W = DIV_WIDTH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  int lat, busyc;
  logic [W-1:0] gq, gr;
  logic gz;
  div_unit_if #(.WIDTH(W)) bus();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    logic sa, sb;
    logic [W-1:0] ua, ub;
    sa = sg & a[W-1];
    sb = sg & b[W-1];
    ua = sa ? -a : a;
    ub = sb ? -b : b;
`ifdef DIV_ZERO_DETECT_EN
    if (b == 0) begin
      q = '1;
      r = a;
      return;
    end
`endif
    q = (ub == 0) ? '1 : ua / ub;
    r = (ub == 0) ? ua : ua % ub;
    if (sa ^ sb) q = -q;
    if (sa) r = -r;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 0) return 1;
`endif
    return W + 1;
  endfunction

  function automatic int exp_busy(input logic [W-1:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 0) return 0;
`endif
    return W;
  endfunction

  task automatic op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i = 1'b1;
    bus.signed_i = sg;
    bus.dividend_i = a;
    bus.divisor_i = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.signed_i = ~sg;
    bus.dividend_i = $urandom;
    bus.divisor_i = $urandom;
    lat = -1;
    busyc = 0;
    for (int n = 1; n <= 100; n++) begin
      busyc += int'(bus.busy_o);
      @(posedge clk); #1;
      if (bus.ready_o) begin
        lat = n;
        break;
      end
    end
    gq = bus.lo_o;
    gr = bus.hi_o;
`ifdef DIV_ZERO_DETECT_EN
    gz = bus.div_zero_o;
`else
    gz = 1'b0;
`endif
  endtask

  task automatic test_reset();
    checks += 4;
    if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    if (bus.ready_o !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
    if (bus.hi_o !== '0) begin errs++; $display("FAIL reset_hi: got %h expected 0", bus.hi_o); end
    if (bus.lo_o !== '0) begin errs++; $display("FAIL reset_lo: got %h expected 0", bus.lo_o); end
  endtask

  task automatic test_directed();
    logic sg [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] da [5] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd5};
    logic [W-1:0] db [5] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0};
    logic [W-1:0] eq [5] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [W-1:0] er [5] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5};
    for (int i = 0; i < 5; i++) begin
      op(sg[i], da[i], db[i]);
      checks += 6;
      if (lat != exp_lat(db[i])) begin errs++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat(db[i])); end
      if (busyc != exp_busy(db[i])) begin errs++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, busyc, exp_busy(db[i])); end
      if (gq !== eq[i]) begin errs++; $display("FAIL dir%0d_lo: got %h expected %h", i, gq, eq[i]); end
      if (gr !== er[i]) begin errs++; $display("FAIL dir%0d_hi: got %h expected %h", i, gr, er[i]); end
`ifdef DIV_ZERO_DETECT_EN
      if (gz !== (db[i] == 0)) begin errs++; $display("FAIL dir%0d_div_zero: got %b expected %b", i, gz, db[i] == 0); end
`else
      if (gz !== 1'b0) begin errs++; $display("FAIL dir%0d_div_zero: got %b expected 0", i, gz); end
`endif
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b0) begin errs++; $display("FAIL dir%0d_ready_pulse: got %b expected 0", i, bus.ready_o); end
    end
  endtask

  task automatic test_random();
    logic sg;
    logic [W-1:0] a, b, q, r;
    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = W'($urandom_range(1, 15));
        1: b = '0;
        2: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      model(sg, a, b, q, r);
      op(sg, a, b);
      checks += 3;
      if (lat != exp_lat(b)) begin errs++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, exp_lat(b)); end
      if (gq !== q) begin errs++; $display("FAIL rnd%0d_lo (s=%b %h/%h): got %h expected %h", i, sg, a, b, gq, q); end
      if (gr !== r) begin errs++; $display("FAIL rnd%0d_hi (s=%b %h/%h): got %h expected %h", i, sg, a, b, gr, r); end
    end
  endtask

  task automatic test_annul();
    logic [W-1:0] ph, pl;
    int seen;
    op(1'b0, 32'd50, 32'd6);
    ph = bus.hi_o;
    pl = bus.lo_o;
    bus.start_i = 1'b1;
    bus.signed_i = 1'b0;
    bus.dividend_i = 32'd100;
    bus.divisor_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL annul_idle: got busy %b expected 0", bus.busy_o); end
    seen = 0;
    repeat (40) begin
      seen += int'(bus.ready_o);
      @(posedge clk); #1;
    end
    checks += 3;
    if (seen != 0) begin errs++; $display("FAIL annul_no_ready: got %0d pulses expected 0", seen); end
    if (bus.hi_o !== ph) begin errs++; $display("FAIL annul_hi_kept: got %h expected %h", bus.hi_o, ph); end
    if (bus.lo_o !== pl) begin errs++; $display("FAIL annul_lo_kept: got %h expected %h", bus.lo_o, pl); end
    op(1'b0, 32'd9, 32'd3);
    checks += 2;
    if (gq !== 32'd3) begin errs++; $display("FAIL annul_next_lo: got %h expected 3", gq); end
    if (gr !== 32'd0) begin errs++; $display("FAIL annul_next_hi: got %h expected 0", gr); end
  endtask

  task automatic test_start_ignored();
    int n;
    bus.start_i = 1'b1;
    bus.signed_i = 1'b0;
    bus.dividend_i = 32'd100;
    bus.divisor_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.start_i = 1'b1;
    bus.signed_i = 1'b1;
    bus.dividend_i = 32'd50;
    bus.divisor_i = 32'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n = 6;
    while (!bus.ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks += 3;
    if (n != W + 1) begin errs++; $display("FAIL ignore_latency: got %0d expected %0d", n, W + 1); end
    if (bus.lo_o !== 32'd14) begin errs++; $display("FAIL ignore_lo: got %h expected 14", bus.lo_o); end
    if (bus.hi_o !== 32'd2) begin errs++; $display("FAIL ignore_hi: got %h expected 2", bus.hi_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    op(1'b0, 32'd1000, 32'd10);
    checks += 2;
    if (gq !== 32'd100) begin errs++; $display("FAIL b2b_first_lo: got %h expected 100", gq); end
    if (gr !== 32'd0) begin errs++; $display("FAIL b2b_first_hi: got %h expected 0", gr); end
    op(1'b1, -32'd1003, 32'd10);
    checks += 3;
    if (lat != W + 1) begin errs++; $display("FAIL b2b_latency: got %0d expected %0d", lat, W + 1); end
    if (gq !== -32'd100) begin errs++; $display("FAIL b2b_second_lo: got %h expected %h", gq, -32'd100); end
    if (gr !== -32'd3) begin errs++; $display("FAIL b2b_second_hi: got %h expected %h", gr, -32'd3); end
  endtask

  task automatic test_async_reset();
    bus.start_i = 1'b1;
    bus.signed_i = 1'b0;
    bus.dividend_i = 32'd100;
    bus.divisor_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL arst_busy: got %b expected 0", bus.busy_o); end
    if (bus.hi_o !== '0) begin errs++; $display("FAIL arst_hi: got %h expected 0", bus.hi_o); end
    if (bus.lo_o !== '0) begin errs++; $display("FAIL arst_lo: got %h expected 0", bus.lo_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    op(1'b0, 32'd9, 32'd3);
    checks += 3;
    if (lat != W + 1) begin errs++; $display("FAIL arst_restart_latency: got %0d expected %0d", lat, W + 1); end
    if (gq !== 32'd3) begin errs++; $display("FAIL arst_restart_lo: got %h expected 3", gq); end
    if (gr !== 32'd0) begin errs++; $display("FAIL arst_restart_hi: got %h expected 0", gr); end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.signed_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_annul();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
